// File: rtl/mem_write_checker.sv
// Scoreboard for core store traffic: compares observed stores against a preloaded
// table of expected (address, data) writes and reports a sticky pass/fail/timeout verdict.
module mem_write_checker #(
  parameter int unsigned       DEPTH      = 4,
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] IGNORE_ADR = ADDR_W'(96),
  parameter bit                IGNORE_EN  = 1'b1,
  parameter bit                STRICT     = 1'b1,
  parameter int unsigned       TIMEOUT    = 1000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [ADDR_W-1:0]            load_adr,
  input  logic [DATA_W-1:0]            load_data,
  input  logic                         start,
  input  logic                         MemWrite,
  input  logic [ADDR_W-1:0]            DataAdr,
  input  logic [DATA_W-1:0]            WriteData,
  output logic                         busy,
  output logic                         pass,
  output logic                         fail,
  output logic                         timeout,
  output logic [$clog2(DEPTH+1)-1:0]   match_count,
  output logic [ADDR_W-1:0]            fail_adr,
  output logic [DATA_W-1:0]            fail_data
);

  localparam int unsigned     CW      = $clog2(DEPTH + 1);
  localparam int unsigned     IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       r_match;
  logic [31:0]         r_tcnt;
  logic                r_pass;
  logic                r_fail;
  logic                r_tout;
  logic [ADDR_W-1:0]   r_fail_adr;
  logic [DATA_W-1:0]   r_fail_data;
  logic [ADDR_W-1:0]   r_adr [DEPTH];
  logic [DATA_W-1:0]   r_dat [DEPTH];

  logic                w_load;
  logic [IW-1:0]       w_tail;
  logic [IW-1:0]       w_head;
  logic                w_ign;
  logic                w_hit;
  logic                w_miss;
  logic [CW-1:0]       w_match_nxt;
  logic [31:0]         w_tnext;

  // Entries are never popped, so the head index is simply the number matched so far.
  assign w_tail      = r_cnt[IW-1:0];
  assign w_head      = r_match[IW-1:0];
  assign w_load      = (r_state == S_IDLE) && load_valid && (r_cnt < DEPTH_C);
  assign w_ign       = IGNORE_EN && (DataAdr == IGNORE_ADR);
  assign w_hit       = MemWrite && !w_ign &&
                       (DataAdr == r_adr[w_head]) && (WriteData == r_dat[w_head]);
  assign w_miss      = MemWrite && !w_ign && !w_hit;
  assign w_match_nxt = r_match + CW'(1);
  assign w_tnext     = r_tcnt + 32'd1;

  always_ff @(posedge clk) begin
    if (w_load) begin
      r_adr[w_tail] <= load_adr;
      r_dat[w_tail] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_match     <= '0;
      r_tcnt      <= '0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_tout      <= 1'b0;
      r_fail_adr  <= '0;
      r_fail_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_load) r_cnt <= r_cnt + CW'(1);
          if (start) begin
            r_tcnt  <= '0;
            r_match <= '0;
            if ((r_cnt == '0) && !w_load) begin
              r_state <= S_PASS;
              r_pass  <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          // A store on the deadline cycle is evaluated before the timeout.
          if (w_hit) begin
            r_match <= w_match_nxt;
            r_tcnt  <= '0;
            if (w_match_nxt == r_cnt) begin
              r_state <= S_PASS;
              r_pass  <= 1'b1;
            end
          end else if (w_miss && STRICT) begin
            r_state     <= S_FAIL;
            r_fail      <= 1'b1;
            r_fail_adr  <= DataAdr;
            r_fail_data <= WriteData;
          end else if (TIMEOUT != 0) begin
            if (w_tnext == TIMEOUT) begin
              r_state     <= S_FAIL;
              r_fail      <= 1'b1;
              r_tout      <= 1'b1;
              r_fail_adr  <= '0;
              r_fail_data <= '0;
            end else begin
              r_tcnt <= w_tnext;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign load_ready  = (r_state == S_IDLE) && (r_cnt < DEPTH_C);
  assign busy        = (r_state == S_RUN);
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign timeout     = r_tout;
  assign match_count = r_match;
  assign fail_adr    = r_fail_adr;
  assign fail_data   = r_fail_data;

endmodule
